fanin4_rr_merge: RTL and testbench

FANIN4_RR_MERGE -- requirements
Module: fanin4_rr_merge

---
 rtl/fanin_pkg.sv | 13 +
 rtl/rr_arb4.sv | 51 +++++
 rtl/fanin4_rr_merge.sv | 95 +++++++++
 tb/tb_fanin4_rr_merge.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/fanin_pkg.sv
// Shared definitions for the four-port round-robin merge: port count,
// port-index type and a small index-to-one-hot helper.
package fanin_pkg;

   localparam int NUM_PORTS = 4;

   typedef logic [1:0] port_idx_t;

   function automatic logic [NUM_PORTS-1:0] idx_to_onehot(input port_idx_t idx);
      return 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/rr_arb4.sv
// Four-way round-robin arbiter: rotating pointer, priority search from the
// pointer upward (mod 4), one-hot grant gated by the enable.
module rr_arb4
   import fanin_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_PORTS-1:0] req_i,
   input  logic                 en_i,
   output logic [NUM_PORTS-1:0] grant_o,
   output port_idx_t            grant_idx_o,
   output logic                 grant_vld_o
);

   port_idx_t ptr_q;
   port_idx_t ptr_d;
   port_idx_t cand_s [NUM_PORTS];
   port_idx_t sel_idx_s;
   logic      found_s;
   logic      grant_vld_s;

   // Priority search starting at the pointer; the first requester wins.
   always_comb begin
      found_s   = 1'b0;
      sel_idx_s = ptr_q;
      for (int k = 0; k < NUM_PORTS; k++) begin
         cand_s[k] = ptr_q + port_idx_t'(k);
         sel_idx_s = (!found_s && req_i[cand_s[k]]) ? cand_s[k] : sel_idx_s;
         found_s   = found_s | req_i[cand_s[k]];
      end
   end

   // Grant is only issued when the downstream register can take the beat.
   always_comb begin
      grant_vld_s = found_s & en_i;
      grant_o     = grant_vld_s ? idx_to_onehot(sel_idx_s) : {NUM_PORTS{1'b0}};
      grant_idx_o = sel_idx_s;
      grant_vld_o = grant_vld_s;
      ptr_d       = grant_vld_s ? (sel_idx_s + 2'd1) : ptr_q;
   end

   // Pointer register: moves past the winner on every transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= 2'd0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/fanin4_rr_merge.sv
// Merges four valid/ready streams into one registered output stream with
// round-robin fairness and a wrapping count of output handshakes.
module fanin4_rr_merge
   import fanin_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_PORTS-1:0]          in_valid,
   input  logic [NUM_PORTS*DATA_W-1:0]   in_data,
   output logic [NUM_PORTS-1:0]          in_ready,
   output logic                          out_valid,
   output logic [DATA_W-1:0]             out_data,
   output logic [1:0]                    out_src,
   input  logic                          out_ready,
   output logic [CNT_W-1:0]              xfer_cnt
);

   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q,  out_data_d;
   port_idx_t         out_src_q,   out_src_d;
   logic [CNT_W-1:0]  cnt_q,       cnt_d;

   logic [NUM_PORTS-1:0] grant_s;
   port_idx_t            grant_idx_s;
   logic                 in_xfer_s;
   logic                 out_hs_s;
   logic                 reg_free_s;
   logic [DATA_W-1:0]    sel_data_s;

   // Reset blocks every grant so no input handshake can happen in a reset cycle.
   assign reg_free_s = (~out_valid_q | out_ready) & ~rst;
   assign out_hs_s   = out_valid_q & out_ready;

   rr_arb4 u_arb (
      .clk         (clk),
      .rst         (rst),
      .req_i       (in_valid),
      .en_i        (reg_free_s),
      .grant_o     (grant_s),
      .grant_idx_o (grant_idx_s),
      .grant_vld_o (in_xfer_s)
   );

   assign in_ready = grant_s;

   // One-hot payload mux driven by the grant.
   always_comb begin
      sel_data_s = {DATA_W{1'b0}};
      for (int i = 0; i < NUM_PORTS; i++) begin
         sel_data_s = sel_data_s |
                      (grant_s[i] ? in_data[i*DATA_W +: DATA_W] : {DATA_W{1'b0}});
      end
   end

   // Output register next state: load on input transfer, drain on handshake.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      if (in_xfer_s) begin
         out_valid_d = 1'b1;
         out_data_d  = sel_data_s;
         out_src_d   = grant_idx_s;
      end else if (out_hs_s) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
      cnt_d = out_hs_s ? (cnt_q + CNT_W'(1)) : cnt_q;
   end

   // State registers; a held beat is dropped and not counted on reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= {DATA_W{1'b0}};
         out_src_q   <= 2'd0;
         cnt_q       <= {CNT_W{1'b0}};
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
         cnt_q       <= cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_src   = out_src_q;
   assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_fanin4_rr_merge.sv
// Self-checking bench for fanin4_rr_merge: directed scenarios followed by
// random traffic, all compared against a cycle-level behavioural model.
module tb_fanin4_rr_merge;

   localparam int DW = 8;
   localparam int CW = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [3:0]      in_valid;
   logic [4*DW-1:0] in_data;
   logic [3:0]      in_ready;
   logic            out_valid;
   logic [DW-1:0]   out_data;
   logic [1:0]      out_src;
   logic            out_ready;
   logic [CW-1:0]   xfer_cnt;

   int n_checks = 0;
   int n_errors = 0;

   // Behavioural model state
   bit            m_valid;
   logic [DW-1:0] m_data;
   int            m_src;
   int            m_ptr;
   int            m_cnt;

   fanin4_rr_merge #(.DATA_W(DW), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_ready (out_ready),
      .xfer_cnt  (xfer_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs, check ready, advance model, check outputs.
   task automatic cycle(input logic r, input logic [3:0] v, input logic [4*DW-1:0] d,
                        input logic ordy);
      int         g;
      bit         free;
      logic [3:0] exp_rdy;
      rst = r; in_valid = v; in_data = d; out_ready = ordy;
      #1;
      g    = -1;
      free = !m_valid || ordy;
      for (int k = 0; k < 4; k++) begin
         if (g < 0 && v[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
      end
      exp_rdy = (!r && free && g >= 0) ? 4'(1 << g) : 4'b0000;
      check("in_ready", 32'(in_ready), 32'(exp_rdy));
      @(posedge clk);
      if (r) begin
         m_valid = 1'b0; m_data = '0; m_src = 0; m_ptr = 0; m_cnt = 0;
      end else begin
         if (m_valid && ordy) m_cnt = (m_cnt + 1) % (1 << CW);
         if (free && g >= 0) begin
            m_valid = 1'b1;
            m_data  = d[g*DW +: DW];
            m_src   = g;
            m_ptr   = (g + 1) % 4;
         end else if (m_valid && ordy) begin
            m_valid = 1'b0;
         end
      end
      #1;
      check("out_valid", 32'(out_valid), 32'(m_valid));
      check("out_data",  32'(out_data),  32'(m_data));
      check("out_src",   32'(out_src),   32'(m_src));
      check("xfer_cnt",  32'(xfer_cnt),  32'(m_cnt));
   endtask

   initial begin
      rst = 1'b1; in_valid = 4'b0000; in_data = '0; out_ready = 1'b0;
      m_valid = 1'b0; m_data = '0; m_src = 0; m_ptr = 0; m_cnt = 0;

      cycle(1'b1, 4'b0000, 32'h0, 1'b0);
      cycle(1'b1, 4'b0000, 32'h0, 1'b0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_cnt",   32'(xfer_cnt),  32'd0);

      // Single port
      cycle(1'b0, 4'b0100, 32'h00A5_0000, 1'b1);
      check("single_valid", 32'(out_valid), 32'd1);
      check("single_data",  32'(out_data),  32'hA5);
      check("single_src",   32'(out_src),   32'd2);
      cycle(1'b0, 4'b0000, 32'h0, 1'b1);
      check("single_cnt",   32'(xfer_cnt),  32'd1);
      check("single_drain", 32'(out_valid), 32'd0);

      // Fairness from ptr=0, no bubbles
      cycle(1'b1, 4'b0000, 32'h0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, 4'b1111, 32'h4433_2211, 1'b1);
         check("fair_src",   32'(out_src),   32'(i % 4));
         check("fair_valid", 32'(out_valid), 32'd1);
      end

      // Backpressure: beat from port 0 (0x11) held for 5 cycles
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, 4'b1111, 32'h4433_2211, 1'b0);
         check("bp_data", 32'(out_data), 32'h11);
         check("bp_src",  32'(out_src),  32'd0);
         check("bp_rdy",  32'(in_ready), 32'd0);
         check("bp_cnt",  32'(xfer_cnt), 32'd4);
      end

      // Skip path from ptr=1
      cycle(1'b1, 4'b0000, 32'h0, 1'b0);
      cycle(1'b0, 4'b0001, 32'h0000_0077, 1'b1);
      check("skip_ptr0", 32'(dut.u_arb.ptr_q), 32'd1);
      cycle(1'b0, 4'b1001, 32'hC300_00C0, 1'b1);
      check("skip_src3", 32'(out_src), 32'd3);
      check("skip_ptr1", 32'(dut.u_arb.ptr_q), 32'd0);
      cycle(1'b0, 4'b1001, 32'hC300_00C0, 1'b1);
      check("skip_src0", 32'(out_src), 32'd0);
      check("skip_ptr2", 32'(dut.u_arb.ptr_q), 32'd1);

      // Counter wrap: 17 handshakes with a 4-bit counter
      cycle(1'b1, 4'b0000, 32'h0, 1'b0);
      for (int i = 0; i < 17; i++) cycle(1'b0, 4'b0010, 32'(i << 8), 1'b1);
      cycle(1'b0, 4'b0000, 32'h0, 1'b1);
      check("wrap_cnt", 32'(xfer_cnt), 32'd1);

      // Reset mid-stream with a beat held
      cycle(1'b0, 4'b0001, 32'h0000_0055, 1'b0);
      cycle(1'b0, 4'b0001, 32'h0000_0055, 1'b0);
      check("mid_held", 32'(out_valid), 32'd1);
      cycle(1'b1, 4'b1111, 32'h0, 1'b1);
      check("mid_valid", 32'(out_valid), 32'd0);
      check("mid_ptr",   32'(dut.u_arb.ptr_q), 32'd0);
      check("mid_cnt",   32'(xfer_cnt), 32'd0);
      cycle(1'b0, 4'b1010, 32'h0000_3300, 1'b1);
      check("mid_src",   32'(out_src), 32'd1);
      check("mid_data",  32'(out_data), 32'h33);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
               4'($urandom_range(0, 15)),
               32'($urandom),
               ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
